flood_order_engine: RTL and testbench
=====================================

// Module: flood_order_engine
// PURPOSE
//  Parametrised flood-fill ordering engine for the game board. Starting from one cell, it walks
//  every 4-connected cell whose trace bit is 1 and stamps each cell with its visit order (1,2,3..).
//  It explores all four neighbours and holds a LIFO stack of cells still to expand.
//  It runs the whole fill autonomously under a start/done handshake.
//  It sits between the trace capture logic and the spell-matching/scoring logic.
// PARAMETERS
//  ROWS   5  grid rows
//  COLS   5  grid columns
//  ORD_W  5  width of one order field; elaboration error if 2**ORD_W-1 < ROWS*COLS
//  CELLS = ROWS*COLS (localparam); IDX_W = clog2(CELLS) (localparam)
// PORTS
//  clk         in   1              rising-edge clock
//  rst_n       in   1              synchronous active-low reset
//  start       in   1              request a fill; sampled only in IDLE
//  start_cell  in   IDX_W          linear index row*COLS+col of seed cell
//  trace       in   CELLS          1 = cell is part of the drawn path; bit i = cell i
//  busy        out  1              high from the cycle after start is accepted until DONE
//  done        out  1              one-cycle pulse; order_out/count valid from this cycle
//  order_out   out  CELLS*ORD_W    field i at [i*ORD_W +: ORD_W]; 0 = not reached
//  count       out  ORD_W          number of cells stamped
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE; busy=0, done=0, order_out=0, count=0, stack empty.
//  Reset wins over every other input. Mid-fill reset aborts with no done pulse.
//  States: IDLE, POP, CHK_U, CHK_D, CHK_L, CHK_R, DONE.
//  IDLE: if start=1, latch trace and start_cell internally. Later input changes are ignored.
//   Clear order_out and count. If trace[start_cell]=1, stamp start_cell=1, count=1,
//   push start_cell, then go to POP. Otherwise go directly to DONE with count=0.
//  POP: if stack empty -> DONE. Else pop top into cur, then go to CHK_U.
//  CHK_U/D/L/R: one neighbour per cycle, in the order up(row-1), down(row+1), left(col-1),
//   right(col+1). No wrap: skip a neighbour that is off-grid (row 0 up, row ROWS-1 down,
//   col 0 left, col COLS-1 right). A neighbour n qualifies if trace[n]=1 and order[n]=0.
//   On qualify: order[n]<=count+1, count<=count+1, push n.
//   CHK_R -> POP.
//  Each expanded cell costs exactly 5 cycles (POP + 4 CHK).
//  DONE: done=1 for one cycle, busy=0, -> IDLE. order_out and count hold until the next start.
//  busy=1 in POP and CHK_* states only. start while busy or in DONE is ignored (not queued).
//  Stack depth CELLS. Each cell is pushed at most once, so overflow is impossible.
//   An assertion checks this.
//  All index arithmetic uses IDX_W+1 bits; row/col are derived by div/mod COLS
//   or tracked as separate counters.
//  Latency: start accepted at cycle t -> done at t+2+5*N, with N = cells stamped (N>=1);
//   N=0 -> done at t+1.
// TESTING
//  1 5x5, trace=bit0 only, start_cell=0, start at t -> done at t+7, count=1, order[0]=1,
//    all other fields 0.
//  2 5x5, trace bits {0,1,5}, start_cell=0 -> order[0]=1, order[5]=2, order[1]=3, count=3,
//    done at t+17.
//  3 5x5, trace=all ones, start_cell=12 -> count=25; every field in 1..25 and distinct;
//    done at t+127.
//  4 trace[start_cell]=0 -> done at t+1, count=0, order_out=0; also a second region
//    disconnected from the seed stays 0.
//  5 start pulsed again while busy, trace changed mid-fill -> ignored; result equals
//    scenario 2.
//  6 rst_n=0 during CHK_D of scenario 3 -> next cycle busy=0, order_out=0, count=0,
//    no done; restart completes normally.
//  Also: run the ROWS=3, COLS=7, ORD_W=5 variant. Check that edge cells never wrap to the
//    adjacent row.

Source files
------------

// File: rtl/flood_order_engine.sv
// Flood-fill ordering engine: stamps 4-connected traced cells with visit order.
// Ports: clk, rst_n (sync, low), start/start_cell/trace in; busy/done/order_out/count out.
module flood_order_engine #(
  parameter  int ROWS  = 5,
  parameter  int COLS  = 5,
  parameter  int ORD_W = 5,
  localparam int CELLS = ROWS * COLS,
  localparam int IDX_W = $clog2(CELLS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [IDX_W-1:0]         start_cell,
  input  logic [CELLS-1:0]         trace,
  output logic                     busy,
  output logic                     done,
  output logic [CELLS*ORD_W-1:0]   order_out,
  output logic [ORD_W-1:0]         count
);

  if ((2 ** ORD_W) - 1 < CELLS) begin : g_bad_ord_w
    $error("ORD_W too narrow for ROWS*COLS");
  end

  typedef enum logic [2:0] {
    IDLE, POP, CHK_U, CHK_D, CHK_L, CHK_R, DONE
  } state_t;

  localparam logic [IDX_W:0] COLS_W  = (IDX_W+1)'(COLS);
  localparam logic [IDX_W:0] COLS_M1 = (IDX_W+1)'(COLS - 1);
  localparam logic [IDX_W:0] ROWS_M1 = (IDX_W+1)'(ROWS - 1);
  localparam logic [IDX_W:0] CELLS_W = (IDX_W+1)'(CELLS);

  state_t             state_q, state_d;
  logic [CELLS-1:0]   trace_q;
  logic [ORD_W-1:0]   order_q [CELLS];
  logic [ORD_W-1:0]   count_q;
  logic [IDX_W-1:0]   stack_q [CELLS];
  logic [IDX_W:0]     sp_q;
  logic [IDX_W-1:0]   cur_q;

  logic [IDX_W:0]     cur_w, row, col, nb_w;
  logic [IDX_W-1:0]   nb;
  logic               nb_ok, hit, seed_ok;

  assign seed_ok = ({1'b0, start_cell} < CELLS_W)
                && trace[start_cell];

  assign cur_w = {1'b0, cur_q};
  assign row   = cur_w / COLS_W;
  assign col   = cur_w % COLS_W;

  // Neighbour of the cell being expanded; edges never wrap.
  always_comb begin
    nb_w  = '0;
    nb_ok = 1'b0;
    unique case (1'b1)
      (state_q == CHK_U): begin
        nb_w  = cur_w - COLS_W;
        nb_ok = (row != '0);
      end
      (state_q == CHK_D): begin
        nb_w  = cur_w + COLS_W;
        nb_ok = (row != ROWS_M1);
      end
      (state_q == CHK_L): begin
        nb_w  = cur_w - 1'b1;
        nb_ok = (col != '0);
      end
      (state_q == CHK_R): begin
        nb_w  = cur_w + 1'b1;
        nb_ok = (col != COLS_M1);
      end
      default: ;
    endcase
  end

  assign nb  = nb_w[IDX_W-1:0];
  assign hit = nb_ok && (nb_w < CELLS_W)
            && trace_q[nb] && (order_q[nb] == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = seed_ok ? POP : DONE;
      end
      POP: begin
        busy    = 1'b1;
        state_d = (sp_q == '0) ? DONE : CHK_U;
      end
      CHK_U: begin
        busy    = 1'b1;
        state_d = CHK_D;
      end
      CHK_D: begin
        busy    = 1'b1;
        state_d = CHK_L;
      end
      CHK_L: begin
        busy    = 1'b1;
        state_d = CHK_R;
      end
      CHK_R: begin
        busy    = 1'b1;
        state_d = POP;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trace_q <= '0;
      count_q <= '0;
      sp_q    <= '0;
      cur_q   <= '0;
      for (int i = 0; i < CELLS; i++) order_q[i] <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            trace_q <= trace;
            sp_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < CELLS; i++) order_q[i] <= '0;
            if (seed_ok) begin
              order_q[start_cell] <= ORD_W'(1);
              count_q             <= ORD_W'(1);
              stack_q[0]          <= start_cell;
              sp_q                <= (IDX_W+1)'(1);
            end
          end
        end
        POP: begin
          if (sp_q != '0) begin
            cur_q <= stack_q[IDX_W'(sp_q - 1'b1)];
            sp_q  <= sp_q - 1'b1;
          end
        end
        CHK_U, CHK_D, CHK_L, CHK_R: begin
          if (hit) begin
            assert (sp_q < CELLS_W);
            order_q[nb]           <= count_q + 1'b1;
            count_q               <= count_q + 1'b1;
            stack_q[IDX_W'(sp_q)] <= nb;
            sp_q                  <= sp_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    order_out = '0;
    for (int i = 0; i < CELLS; i++)
      order_out[i*ORD_W +: ORD_W] = order_q[i];
  end

  assign count = count_q;

endmodule

// File: tb/tb_flood_order_engine.sv
// Bench for flood_order_engine: 5x5 and 3x7 instances, scoreboarded fills.
// Expected orders come from a reference flood model; latency 1 or 2+5N.
module tb_flood_order_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          a_start, a_busy, a_done;
  logic [4:0]    a_seed, a_cnt;
  logic [24:0]   a_trace;
  logic [124:0]  a_ord;
  logic          b_start, b_busy, b_done;
  logic [4:0]    b_seed, b_cnt;
  logic [20:0]   b_trace;
  logic [104:0]  b_ord;

  flood_order_engine #(.ROWS(5), .COLS(5), .ORD_W(5)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .start_cell(a_seed),
    .trace(a_trace), .busy(a_busy), .done(a_done),
    .order_out(a_ord), .count(a_cnt)
  );

  flood_order_engine #(.ROWS(3), .COLS(7), .ORD_W(5)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .start_cell(b_seed),
    .trace(b_trace), .busy(b_busy), .done(b_done),
    .order_out(b_ord), .count(b_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int           lat;
    int           cnt;
    logic [159:0] vec;
  } exp_t;
  exp_t sb[$];

  function automatic void model(input int rows, input int cols,
                                input int seed, input logic [31:0] tr,
                                output int cnt, output logic [159:0] vec);
    int ord[32];
    int stk[$];
    int cur, r, c, n;
    bit ok;
    for (int i = 0; i < 32; i++) ord[i] = 0;
    cnt = 0;
    vec = '0;
    if (tr[seed]) begin
      cnt = 1;
      ord[seed] = 1;
      stk.push_back(seed);
    end
    while (stk.size() > 0) begin
      cur = stk.pop_back();
      r = cur / cols;
      c = cur % cols;
      for (int d = 0; d < 4; d++) begin
        case (d)
          0:       begin ok = (r > 0);        n = cur - cols; end
          1:       begin ok = (r < rows - 1); n = cur + cols; end
          2:       begin ok = (c > 0);        n = cur - 1;    end
          default: begin ok = (c < cols - 1); n = cur + 1;    end
        endcase
        if (ok) begin
          if (tr[n] && ord[n] == 0) begin
            cnt++;
            ord[n] = cnt;
            stk.push_back(n);
          end
        end
      end
    end
    for (int i = 0; i < rows * cols; i++) vec[i*5 +: 5] = 5'(ord[i]);
  endfunction

  function automatic logic [159:0] get_vec(input int w);
    return (w == 0) ? {35'b0, a_ord} : {55'b0, b_ord};
  endfunction

  function automatic int get_cnt(input int w);
    return (w == 0) ? int'(a_cnt) : int'(b_cnt);
  endfunction

  function automatic logic get_done(input int w);
    return (w == 0) ? a_done : b_done;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 0) ? a_busy : b_busy;
  endfunction

  task automatic set_in(input int w, input int seed,
                        input logic [31:0] tr, input logic go);
    if (w == 0) begin
      a_start = go;
      a_seed  = 5'(seed);
      a_trace = tr[24:0];
    end else begin
      b_start = go;
      b_seed  = 5'(seed);
      b_trace = tr[20:0];
    end
  endtask

  task automatic chk(input string tag, input logic [159:0] obs,
                     input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input int w, input int seed,
                     input logic [31:0] tr, input bit disturb);
    exp_t e, x;
    int rows, cols, c_a, got_lat;
    bit seen;
    rows = (w != 0) ? 3 : 5;
    cols = (w != 0) ? 7 : 5;
    model(rows, cols, seed, tr, e.cnt, e.vec);
    e.lat = (e.cnt == 0) ? 1 : 2 + 5 * e.cnt;
    sb.push_back(e);
    set_in(w, seed, tr, 1'b1);
    @(posedge clk); #1;
    set_in(w, seed, tr, 1'b0);
    c_a = cyc;
    chk({tag, ".busy"}, 160'(get_busy(w)), 160'(e.cnt > 0));
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (get_done(w)) begin
        seen = 1'b1;
        break;
      end
      if (disturb && k == 3) set_in(w, 12, 32'hFFFF_FFFF, 1'b1);
      if (disturb && k == 4) set_in(w, 12, 32'hFFFF_FFFF, 1'b0);
      @(posedge clk); #1;
    end
    got_lat = cyc - c_a + 1;
    x = sb.pop_front();
    chk({tag, ".done_seen"}, 160'(seen), 160'(1));
    chk({tag, ".latency"}, 160'(got_lat), 160'(x.lat));
    chk({tag, ".count"}, 160'(get_cnt(w)), 160'(x.cnt));
    chk({tag, ".order"}, get_vec(w), x.vec);
    chk({tag, ".busy_at_done"}, 160'(get_busy(w)), 160'(0));
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, 160'(get_done(w)), 160'(0));
    chk({tag, ".order_hold"}, get_vec(w), x.vec);
    set_in(w, seed, tr, 1'b0);
  endtask

  logic [31:0] t2;
  logic [25:0] mask;
  int          v;
  bit          bad_done;

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 32'h0, 1'b0);
    set_in(1, 0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.a_busy", 160'(a_busy), 160'(0));
    chk("rst.a_done", 160'(a_done), 160'(0));
    chk("rst.a_count", 160'(a_cnt), 160'(0));
    chk("rst.a_order", get_vec(0), 160'(0));
    chk("rst.b_order", get_vec(1), 160'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    run("s1", 0, 0, 32'h1, 1'b0);

    t2 = (32'd1 << 0) | (32'd1 << 1) | (32'd1 << 5);
    run("s2", 0, 0, t2, 1'b0);
    chk("s2.ord5", 160'(a_ord[25 +: 5]), 160'(2));
    chk("s2.ord1", 160'(a_ord[5 +: 5]), 160'(3));

    run("s3", 0, 12, 32'h01FF_FFFF, 1'b0);
    mask = '0;
    for (int i = 0; i < 25; i++) begin
      v = int'(a_ord[i*5 +: 5]);
      if (v >= 1 && v <= 25) mask[v] = 1'b1;
    end
    chk("s3.distinct", 160'(mask), 160'(26'h3FF_FFFE));

    run("s4.noseed", 0, 7, (32'd1 << 12) | (32'd1 << 13), 1'b0);
    run("s4.island", 0, 0,
        32'h3 | (32'd1 << 12) | (32'd1 << 13), 1'b0);
    chk("s4.island_12", 160'(a_ord[60 +: 5]), 160'(0));

    run("s5", 0, 0, t2, 1'b1);
    chk("s5.ord0", 160'(a_ord[0 +: 5]), 160'(1));
    chk("s5.ord5", 160'(a_ord[25 +: 5]), 160'(2));
    chk("s5.ord1", 160'(a_ord[5 +: 5]), 160'(3));

    run("e.rwrap5", 0, 4, (32'd1 << 4) | (32'd1 << 5), 1'b0);
    run("e.lwrap5", 0, 5, (32'd1 << 4) | (32'd1 << 5), 1'b0);

    set_in(0, 12, 32'h01FF_FFFF, 1'b1);
    @(posedge clk); #1;
    set_in(0, 12, 32'h01FF_FFFF, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("s6.busy", 160'(a_busy), 160'(0));
    chk("s6.count", 160'(a_cnt), 160'(0));
    chk("s6.order", get_vec(0), 160'(0));
    rst_n = 1'b1;
    bad_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (a_done) bad_done = 1'b1;
      @(posedge clk); #1;
    end
    chk("s6.no_done", 160'(bad_done), 160'(0));
    run("s6.restart", 0, 12, 32'h01FF_FFFF, 1'b0);

    run("w.all", 1, 0, 32'h001F_FFFF, 1'b0);
    run("w.rwrap", 1, 6, (32'd1 << 6) | (32'd1 << 7), 1'b0);
    run("w.lwrap", 1, 7, (32'd1 << 6) | (32'd1 << 7), 1'b0);
    run("w.vert", 1, 0, (32'd1 << 0) | (32'd1 << 14), 1'b0);
    run("w.mixed", 1, 10, 32'h0015_AD6B | (32'd1 << 10), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
